// File: rtl/snake_grid_render_if.sv
// snake_grid_render_if: frame-request bus between the snake producer
// and the occupancy-grid renderer.
interface snake_grid_render_if #(
    parameter int COORD_W = 4,
    parameter int SEG_W   = 8,
    parameter int MAX_SEG = 225
);
    localparam int CELLS = 1 << (2 * COORD_W);

    logic                     load;
    logic [MAX_SEG*SEG_W-1:0] snake;
    logic [7:0]               seg_count;
    logic [SEG_W-1:0]         food;
    logic                     busy;
    logic                     done;
    logic [CELLS-1:0]         grid;
    logic                     self_hit;
    logic                     food_hit;

    modport master (
        output load, snake, seg_count, food,
        input  busy, done, grid, self_hit, food_hit
    );

    modport slave (
        input  load, snake, seg_count, food,
        output busy, done, grid, self_hit, food_hit
    );
endinterface

// File: rtl/snake_grid_render.sv
// snake_grid_render: snapshots a snake body vector, walks it one segment
// per clock into a 16x16 occupancy bitmap, then commits grid and hit flags.
module snake_grid_render #(
    parameter int COORD_W = 4,
    parameter int SEG_W   = 8,
    parameter int MAX_SEG = 225
) (
    input logic                slw_clk,
    input logic                reset,
    snake_grid_render_if.slave bus
);
    localparam int CELLS = 1 << (2 * COORD_W);
    localparam int VEC_W = MAX_SEG * SEG_W;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    state_t             state;
    logic [VEC_W-1:0]   snap;
    logic [SEG_W-1:0]   food_snap;
    logic [7:0]         cnt;
    logic [7:0]         idx;
    logic [CELLS-1:0]   work;
    logic               hit_acc;
    logic               food_acc;
    logic [CELLS-1:0]   grid;
    logic               self_hit;
    logic               food_hit;
    logic               done;
    logic               busy;

    logic [SEG_W-1:0]   seg;
    logic [7:0]         cnt_in;
    logic               is_head;

    // Snapshot is shifted down each SCAN step, so the current segment
    // always sits in the low byte.
    assign seg     = snap[SEG_W-1:0];
    assign is_head = (idx == cnt - 8'd1);
    assign cnt_in  = (bus.seg_count > 8'(MAX_SEG)) ?
                     8'(MAX_SEG) : bus.seg_count;

    assign bus.grid     = grid;
    assign bus.self_hit = self_hit;
    assign bus.food_hit = food_hit;
    assign bus.done     = done;
    assign bus.busy     = busy;

    // Frame FSM: capture on load, scan segments, commit results.
    always_ff @(posedge slw_clk) begin
        if (!reset) begin
            state     <= IDLE;
            snap      <= '0;
            food_snap <= '0;
            cnt       <= '0;
            idx       <= '0;
            work      <= '0;
            hit_acc   <= 1'b0;
            food_acc  <= 1'b0;
            grid      <= '0;
            self_hit  <= 1'b0;
            food_hit  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.load) begin
                        snap      <= bus.snake;
                        food_snap <= bus.food;
                        cnt       <= cnt_in;
                        work      <= '0;
                        idx       <= '0;
                        hit_acc   <= 1'b0;
                        food_acc  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (cnt_in != 8'd0) ? SCAN : COMMIT;
                    end
                end
                SCAN: begin
                    work[seg] <= 1'b1;
                    if (is_head) begin
                        hit_acc  <= work[seg];
                        food_acc <= (seg == food_snap);
                        state    <= COMMIT;
                    end else begin
                        idx  <= idx + 8'd1;
                        snap <= snap >> SEG_W;
                    end
                end
                COMMIT: begin
                    grid     <= work;
                    self_hit <= hit_acc;
                    food_hit <= food_acc;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_grid_render.sv
// tb_snake_grid_render: directed and random frames checked against an
// array-based model of the snake occupancy rules.
module tb_snake_grid_render;
    logic slw_clk = 1'b0;
    logic reset   = 1'b0;

    snake_grid_render_if bus ();

    snake_grid_render dut (
        .slw_clk (slw_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 slw_clk = ~slw_clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [255:0] exp_grid;
    logic         exp_self;
    logic         exp_food;
    int           exp_lat;

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: which cells the first min(count,225) bytes cover, and
    // whether the last of them repeats an earlier byte or equals food.
    task automatic model(input logic [1799:0] sv, input logic [7:0] sc,
                         input logic [7:0] fd);
        int c;
        logic [7:0] b;
        logic [7:0] head;
        c = (sc > 225) ? 225 : int'(sc);
        exp_grid = '0;
        exp_self = 1'b0;
        exp_food = 1'b0;
        for (int k = 0; k < c; k++) begin
            b = sv[8*k +: 8];
            exp_grid[b] = 1'b1;
        end
        if (c > 0) begin
            head = sv[8*(c-1) +: 8];
            for (int k = 0; k < c - 1; k++)
                if (sv[8*k +: 8] == head) exp_self = 1'b1;
            exp_food = (head == fd);
        end
        exp_lat = c + 1;
    endtask

    task automatic set_frame(input logic [7:0] segs[$],
                             input logic [7:0] sc, input logic [7:0] fd);
        for (int k = 0; k < 225; k++)
            bus.snake[8*k +: 8] = 8'($urandom);
        foreach (segs[i])
            bus.snake[8*i +: 8] = segs[i];
        bus.seg_count = sc;
        bus.food      = fd;
    endtask

    // Called #1 after an edge with inputs set; the next edge is E0.
    task automatic run_frame(string tag, input bit disturb);
        int lat;
        model(bus.snake, bus.seg_count, bus.food);
        bus.load = 1'b1;
        @(posedge slw_clk);
        #1;
        bus.load = 1'b0;
        check({tag, " busy_start"}, 256'(bus.busy), 256'(1));
        lat = 0;
        while (!bus.done && lat < 300) begin
            @(posedge slw_clk);
            #1;
            lat++;
            if (disturb && lat == 2) begin
                bus.load = 1'b1;
                for (int k = 0; k < 225; k++)
                    bus.snake[8*k +: 8] = 8'($urandom);
                bus.food = 8'($urandom);
            end
            if (disturb && lat == 3) bus.load = 1'b0;
        end
        check({tag, " done"}, 256'(bus.done), 256'(1));
        check({tag, " latency"}, 256'(lat), 256'(exp_lat));
        check({tag, " grid"}, bus.grid, exp_grid);
        check({tag, " self_hit"}, 256'(bus.self_hit), 256'(exp_self));
        check({tag, " food_hit"}, 256'(bus.food_hit), 256'(exp_food));
        check({tag, " busy_end"}, 256'(bus.busy), 256'(0));
        @(posedge slw_clk);
        #1;
        check({tag, " done_pulse"}, 256'(bus.done), 256'(0));
    endtask

    initial begin
        logic [7:0] q[$];
        int c;
        bit seen;
        bus.load      = 1'b1;
        bus.snake     = '0;
        bus.seg_count = '0;
        bus.food      = '0;

        q = '{8'h11, 8'h12, 8'h13};
        set_frame(q, 8'd3, 8'h33);
        reset = 1'b0;
        repeat (2) @(posedge slw_clk);
        #1;
        check("rst grid", bus.grid, 256'(0));
        check("rst done", 256'(bus.done), 256'(0));
        check("rst busy", 256'(bus.busy), 256'(0));
        check("rst self", 256'(bus.self_hit), 256'(0));
        check("rst food", 256'(bus.food_hit), 256'(0));
        reset = 1'b1;
        run_frame("start", 1'b0);

        bus.snake = '1;
        bus.food  = 8'h00;
        repeat (4) @(posedge slw_clk);
        #1;
        check("idle hold", bus.grid, exp_grid);

        q = '{8'h31, 8'h32, 8'h33};
        set_frame(q, 8'd3, 8'h33);
        run_frame("food", 1'b0);

        q = '{8'h11, 8'h12, 8'h22, 8'h21, 8'h11};
        set_frame(q, 8'd5, 8'h00);
        run_frame("selfhit", 1'b0);

        q = '{8'h11, 8'h12, 8'h11, 8'h13};
        set_frame(q, 8'd4, 8'h00);
        run_frame("dup_body", 1'b0);

        q = '{};
        set_frame(q, 8'd0, 8'h00);
        run_frame("empty", 1'b0);

        bus.snake     = '1;
        bus.seg_count = 8'd255;
        bus.food      = 8'h00;
        run_frame("clamp", 1'b0);

        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        set_frame(q, 8'd6, 8'h06);
        run_frame("disturb", 1'b1);

        q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        set_frame(q, 8'd5, 8'h45);
        bus.load = 1'b1;
        @(posedge slw_clk);
        #1;
        bus.load = 1'b0;
        repeat (2) @(posedge slw_clk);
        #1;
        reset = 1'b0;
        @(posedge slw_clk);
        #1;
        reset = 1'b1;
        check("midrst grid", bus.grid, 256'(0));
        check("midrst busy", 256'(bus.busy), 256'(0));
        check("midrst done", 256'(bus.done), 256'(0));
        check("midrst self", 256'(bus.self_hit), 256'(0));
        check("midrst food", 256'(bus.food_hit), 256'(0));
        seen = 1'b0;
        repeat (10) begin
            @(posedge slw_clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        check("midrst no_done", 256'(seen), 256'(0));

        for (int f = 0; f < 25; f++) begin
            c = $urandom_range(0, 40);
            q = '{};
            for (int i = 0; i < c; i++)
                q.push_back({2'b00, 2'($urandom), 2'b00, 2'($urandom)});
            if (c > 0 && $urandom_range(0, 1) == 1)
                set_frame(q, 8'(c), q[c-1]);
            else
                set_frame(q, 8'(c), {2'b00, 2'($urandom), 2'b00, 2'($urandom)});
            run_frame($sformatf("rand%0d", f), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end
endmodule
